// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster scan generator.
// Two registered FSMs (horizontal and vertical) track the porch/sync/visible
// regions alongside the DrawX/DrawY position counters. hs, vs, display_en
// and frame_start are registered from the next-state position so they always
// describe the DrawX/DrawY values present in the same cycle.
// Optional build macro: VGA_CLKDIV_EN -- when defined, a divider flop halves
// the pixel rate (scan advances every second CLK); when undefined the scan
// advances on every CLK edge.
module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       CLK,
    input  logic       Reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       display_en,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject timings that do not fit the 10-bit position counters, or that
    // have an empty region (the FSMs assume every region is at least 1 wide).
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_too_big
            $error("vga_scan_gen: H_TOTAL and V_TOTAL must be <= 1024");
        end
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_empty_region
            $error("vga_scan_gen: every timing region must be at least 1 wide");
        end
    endgenerate

    // Last position of each region, sized to the counters.
    localparam logic [9:0] X_VIS_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] X_FRONT_LAST = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] X_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] X_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_VIS_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] Y_FRONT_LAST = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] Y_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] Y_LAST       = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        H_ST_VIS   = 2'd0,
        H_ST_FRONT = 2'd1,
        H_ST_SYNC  = 2'd2,
        H_ST_BACK  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ST_VIS   = 2'd0,
        V_ST_FRONT = 2'd1,
        V_ST_SYNC  = 2'd2,
        V_ST_BACK  = 2'd3
    } v_state_t;

    h_state_t   h_state_q;
    v_state_t   v_state_q;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q;
    logic       vs_q;
    logic       de_q;
    logic       fs_q;

    logic       x_last;
    logic       y_last;
    logic       line_end;
    logic       h_vis_d;
    logic       v_vis_d;

`ifdef VGA_CLKDIV_EN
    logic div_q;

    // Divider flop: toggles every CLK; the scan advances when it is high,
    // so the first advance lands on the second edge after reset release.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign pix_tick = div_q;
`else
    assign pix_tick = 1'b1;
`endif

    // Next-position arithmetic and visibility of the position being entered.
    always_comb begin
        x_last   = (x_q == X_LAST);
        y_last   = (y_q == Y_LAST);
        line_end = pix_tick && x_last;
        x_d      = x_last ? 10'd0 : x_q + 10'd1;
        y_d      = y_last ? 10'd0 : y_q + 10'd1;
        // Entering column 0 is visible; otherwise stay visible until the last
        // visible column is left.
        h_vis_d  = x_last || (h_state_q == H_ST_VIS && x_q != X_VIS_LAST);
        if (x_last) begin
            v_vis_d = y_last || (v_state_q == V_ST_VIS && y_q != Y_VIS_LAST);
        end else begin
            v_vis_d = (v_state_q == V_ST_VIS);
        end
    end

    // Horizontal FSM: column counter, region state and registered hs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            h_state_q <= H_ST_BACK;
            x_q       <= X_LAST;
            hs_q      <= 1'b1;
        end else if (pix_tick) begin
            x_q <= x_d;
            case (h_state_q)
                H_ST_VIS: begin
                    if (x_q == X_VIS_LAST) begin
                        h_state_q <= H_ST_FRONT;
                    end
                end
                H_ST_FRONT: begin
                    if (x_q == X_FRONT_LAST) begin
                        h_state_q <= H_ST_SYNC;
                        hs_q      <= 1'b0;
                    end
                end
                H_ST_SYNC: begin
                    if (x_q == X_SYNC_LAST) begin
                        h_state_q <= H_ST_BACK;
                        hs_q      <= 1'b1;
                    end
                end
                default: begin
                    if (x_q == X_LAST) begin
                        h_state_q <= H_ST_VIS;
                    end
                end
            endcase
        end
    end

    // Vertical FSM: line counter, region state and registered vs; it moves
    // only on the tick that wraps the column counter.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            v_state_q <= V_ST_BACK;
            y_q       <= Y_LAST;
            vs_q      <= 1'b1;
        end else if (line_end) begin
            y_q <= y_d;
            case (v_state_q)
                V_ST_VIS: begin
                    if (y_q == Y_VIS_LAST) begin
                        v_state_q <= V_ST_FRONT;
                    end
                end
                V_ST_FRONT: begin
                    if (y_q == Y_FRONT_LAST) begin
                        v_state_q <= V_ST_SYNC;
                        vs_q      <= 1'b0;
                    end
                end
                V_ST_SYNC: begin
                    if (y_q == Y_SYNC_LAST) begin
                        v_state_q <= V_ST_BACK;
                        vs_q      <= 1'b1;
                    end
                end
                default: begin
                    if (y_q == Y_LAST) begin
                        v_state_q <= V_ST_VIS;
                    end
                end
            endcase
        end
    end

    // Registered display enable and frame pulse for the position being entered.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            de_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (pix_tick) begin
            de_q <= h_vis_d && v_vis_d;
            fs_q <= x_last && y_last;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign display_en  = de_q;
    assign frame_start = fs_q;

endmodule
